// File: rtl/shift_req_sequencer_pkg.sv
// shift_pkg: opcodes, FSM states, widths and bit-reverse helper for the shift request sequencer
package shift_pkg;
  localparam int DATA_W = 32;
  localparam int SH_AMT_W = 5;
  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction
  function automatic logic is_left(input logic [2:0] op);
    return op == OP_SLL || op == OP_ROL;
  endfunction
endpackage

// File: rtl/shift_req_sequencer_if.sv
// shift_req_sequencer_if: request, shifter and response signals of the shift sequencer
interface shift_req_sequencer_if #(parameter int TAG_W = 4);
  import shift_pkg::*;
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic [DATA_W-1:0]   req_data;
  logic [SH_AMT_W-1:0] req_amt;
  logic [TAG_W-1:0]    req_tag;
  logic [DATA_W-1:0]   sh_in;
  logic                sh_rotate;
  logic [SH_AMT_W-1:0] sh_select;
  logic [DATA_W-1:0]   sh_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_zero;
  logic                rsp_err;
  logic [TAG_W-1:0]    rsp_tag;
  modport slave (
    input  req_valid, req_op, req_data, req_amt, req_tag, sh_out, rsp_ready,
    output req_ready, sh_in, sh_rotate, sh_select, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag
  );
  modport master (
    output req_valid, req_op, req_data, req_amt, req_tag, sh_out, rsp_ready,
    input  req_ready, sh_in, sh_rotate, sh_select, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag
  );
endinterface

// File: rtl/shift_result_fix.sv
// shift_result_fix: turns right-shifter output into the final result (left via reversal, arithmetic fill, zero flag)
module shift_result_fix
  import shift_pkg::*;
(
  input  logic [2:0]          op_i,
  input  logic [SH_AMT_W-1:0] amt_i,
  input  logic                sign_i,
  input  logic [DATA_W-1:0]   sh_out_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                zero_o
);
  // left ops were reversed going in, so reverse back; SRA ORs in the vacated high bits
  always_comb begin
    data_o = is_left(op_i) ? bit_rev(sh_out_i)
           : (op_i == OP_SRA && sign_i) ? sh_out_i | ~({DATA_W{1'b1}} >> amt_i)
           : sh_out_i;
    zero_o = data_o == '0;
  end
endmodule

// File: rtl/shift_req_sequencer.sv
// shift_req_sequencer: issues shift requests to the right shifter, waits its latency and returns the fixed-up result
module shift_req_sequencer
  import shift_pkg::*;
#(
  parameter int SH_LAT = 1,
  parameter int TAG_W  = 4
) (
  input logic clk,
  input logic reset,
  shift_req_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(SH_LAT + 2);
  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic [DATA_W-1:0]   sh_in_q, sh_in_d;
  logic                sh_rotate_q, sh_rotate_d;
  logic [SH_AMT_W-1:0] sh_select_q, sh_select_d;
  logic [2:0]          op_q, op_d;
  logic [SH_AMT_W-1:0] amt_q, amt_d;
  logic                sign_q, sign_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0]   fix_data;
  logic                fix_zero;
  logic                accept;
  shift_result_fix u_fix (
    .op_i    (op_q),
    .amt_i   (amt_q),
    .sign_i  (sign_q),
    .sh_out_i(bus.sh_out),
    .data_o  (fix_data),
    .zero_o  (fix_zero)
  );
  assign accept        = bus.req_valid & req_ready_q;
  assign bus.req_ready = req_ready_q;
  assign bus.sh_in     = sh_in_q;
  assign bus.sh_rotate = sh_rotate_q;
  assign bus.sh_select = sh_select_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tag   = rsp_tag_q;
  // next state: accept/issue in IDLE, count shifter latency in WAIT, hold response in DONE
  always_comb begin
    state_d     = state_q;
    sh_in_d     = sh_in_q;
    sh_rotate_d = sh_rotate_q;
    sh_select_d = sh_select_q;
    op_d        = op_q;
    amt_d       = amt_q;
    sign_d      = sign_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (bus.req_op <= OP_ROL) begin
          sh_in_d     = is_left(bus.req_op) ? bit_rev(bus.req_data) : bus.req_data;
          sh_rotate_d = bus.req_op == OP_ROR || bus.req_op == OP_ROL;
          sh_select_d = bus.req_amt;
          op_d        = bus.req_op;
          amt_d       = bus.req_amt;
          sign_d      = bus.req_data[DATA_W-1];
          tag_d       = bus.req_tag;
          cnt_d       = CNT_W'(SH_LAT);
          state_d     = S_WAIT;
        end else begin
          rsp_data_d = bus.req_data;
          rsp_zero_d = bus.req_data == '0;
          rsp_err_d  = 1'b1;
          rsp_tag_d  = bus.req_tag;
          state_d    = S_DONE;
        end
      end
      S_WAIT: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        rsp_data_d = fix_data;
        rsp_zero_d = fix_zero;
        rsp_err_d  = 1'b0;
        rsp_tag_d  = tag_q;
        state_d    = S_DONE;
      end
      S_DONE: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = state_d == S_IDLE;
    rsp_valid_d = state_d == S_DONE;
  end
  // all state and outputs clear on reset, dropping any request in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      sh_in_q     <= '0;
      sh_rotate_q <= 1'b0;
      sh_select_q <= '0;
      op_q        <= '0;
      amt_q       <= '0;
      sign_q      <= 1'b0;
      tag_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      sh_in_q     <= sh_in_d;
      sh_rotate_q <= sh_rotate_d;
      sh_select_q <= sh_select_d;
      op_q        <= op_d;
      amt_q       <= amt_d;
      sign_q      <= sign_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end
endmodule

// File: tb/tb_shift_req_sequencer.sv
// tb_shift_req_sequencer: directed checks of the shift sequencer against a registered right shift/rotate model
module tb_shift_req_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  shift_req_sequencer_if #(.TAG_W(4)) bus ();
  shift_req_sequencer #(.SH_LAT(1), .TAG_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  // one-cycle right shifter/rotator sitting beside the sequencer
  always_ff @(posedge clk) begin
    logic [63:0] w;
    w = bus.sh_rotate ? {bus.sh_in, bus.sh_in} >> bus.sh_select : {32'd0, bus.sh_in} >> bus.sh_select;
    bus.sh_out <= w[31:0];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_legal(input logic [2:0] op, input logic [31:0] data, input logic [4:0] amt,
                           input logic [3:0] tag, input logic [31:0] exp, input logic rot, input logic zero);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = data; bus.req_amt = amt; bus.req_tag = tag;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("accept_ready", {31'd0, bus.req_ready}, 32'd0);
    check("sh_select", {27'd0, bus.sh_select}, {27'd0, amt});
    check("sh_rotate", {31'd0, bus.sh_rotate}, {31'd0, rot});
    check("valid_e0", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("valid_e1", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("valid_e2", {31'd0, bus.rsp_valid}, 32'd1);
    check("rsp_data", bus.rsp_data, exp);
    check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, zero});
    check("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, tag});
    @(negedge clk);
    check("valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    check("ready_back", {31'd0, bus.req_ready}, 32'd1);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_data = '0; bus.req_amt = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_sh_in", bus.sh_in, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    run_legal(3'b000, 32'hF0000001, 5'd5, 4'h1, 32'h07800000, 1'b0, 1'b0);
    run_legal(3'b010, 32'hF0000001, 5'd5, 4'h2, 32'h0F800000, 1'b1, 1'b0);
    run_legal(3'b001, 32'h80000000, 5'd4, 4'h3, 32'hF8000000, 1'b0, 1'b0);
    run_legal(3'b001, 32'h40000000, 5'd4, 4'h4, 32'h04000000, 1'b0, 1'b0);
    run_legal(3'b011, 32'h00000001, 5'd31, 4'h5, 32'h80000000, 1'b0, 1'b0);
    run_legal(3'b100, 32'h80000001, 5'd1, 4'h6, 32'h00000003, 1'b1, 1'b0);
    run_legal(3'b000, 32'h00000001, 5'd1, 4'h7, 32'h00000000, 1'b0, 1'b1);
    run_legal(3'b001, 32'h80000000, 5'd0, 4'h8, 32'h80000000, 1'b0, 1'b0);
    run_legal(3'b100, 32'h12345678, 5'd0, 4'hB, 32'h12345678, 1'b1, 1'b0);
    // backpressure
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_data = 32'h12345678; bus.req_amt = 5'd4; bus.req_tag = 4'h3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp_data", bus.rsp_data, 32'h01234567);
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_data = 32'h00000100; bus.req_amt = 5'd8; bus.req_tag = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_hold_data", bus.rsp_data, 32'h01234567);
      check("bp_hold_tag", {28'd0, bus.rsp_tag}, 32'd3);
      check("bp_hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp_not_taken", {27'd0, bus.sh_select}, 32'd4);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_queued_taken", {31'd0, bus.req_ready}, 32'd0);
    check("bp_queued_sel", {27'd0, bus.sh_select}, 32'd8);
    repeat (2) @(negedge clk);
    check("bp_q_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp_q_data", bus.rsp_data, 32'h00000001);
    check("bp_q_tag", {28'd0, bus.rsp_tag}, 32'd5);
    @(negedge clk);
    check("bp_q_drop", {31'd0, bus.rsp_valid}, 32'd0);
    // illegal opcode
    bus.req_valid = 1'b1; bus.req_op = 3'b111; bus.req_data = 32'h00001234; bus.req_amt = 5'd3; bus.req_tag = 4'h9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ill_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("ill_err", {31'd0, bus.rsp_err}, 32'd1);
    check("ill_data", bus.rsp_data, 32'h00001234);
    check("ill_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("ill_tag", {28'd0, bus.rsp_tag}, 32'd9);
    check("ill_sh_in", bus.sh_in, 32'h00000100);
    check("ill_sh_sel", {27'd0, bus.sh_select}, 32'd8);
    @(negedge clk);
    check("ill_drop", {31'd0, bus.rsp_valid}, 32'd0);
    check("ill_ready", {31'd0, bus.req_ready}, 32'd1);
    // reset while waiting on the shifter
    bus.req_valid = 1'b1; bus.req_op = 3'b010; bus.req_data = 32'hDEADBEEF; bus.req_amt = 5'd7; bus.req_tag = 4'hC;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("mid_rst_sh_in", bus.sh_in, 32'd0);
    check("mid_rst_rot", {31'd0, bus.sh_rotate}, 32'd0);
    check("mid_rst_sel", {27'd0, bus.sh_select}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_data", bus.rsp_data, 32'd0);
    check("mid_rst_tag", {28'd0, bus.rsp_tag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    run_legal(3'b000, 32'hFFFFFFFF, 5'd31, 4'hA, 32'h00000001, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
